// File: rtl/conv_sequencer_if.sv
// Control/status bundle between conv_sequencer and the convolution datapath/host.
// Same signal set in both builds (CONV_SEQ_STRIDE2_EN only changes sequencing).
interface conv_sequencer_if;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
    logic       busy;
    logic       done;
    logic       load_filter;
    logic       load_window;
    logic       load_buffer;
    logic       sum_reset;
    logic       sum_en;
    logic       write;
    logic [7:0] address;
    logic [1:0] memory_offset;
    logic [1:0] counter_filter;
    logic [3:0] counter_buffer;
    logic [3:0] counter_sum;
    logic [2:0] k;
    logic [2:0] q;

    modport master (
        output start, x, y, z,
        input  busy, done, load_filter, load_window, load_buffer, sum_reset, sum_en,
               write, address, memory_offset, counter_filter, counter_buffer,
               counter_sum, k, q
    );

    modport slave (
        input  start, x, y, z,
        output busy, done, load_filter, load_window, load_buffer, sum_reset, sum_en,
               write, address, memory_offset, counter_filter, counter_buffer,
               counter_sum, k, q
    );
endinterface

// File: rtl/conv_sequencer.sv
// Sequencer for the 4x4-over-8x8 convolution datapath: loads filter/window, steps sub-windows, writes bytes.
// Define CONV_SEQ_STRIDE2_EN for stride-2 stepping (9 outputs); default is stride 1 (25 outputs).
module conv_sequencer (
    input  logic            clock,
    input  logic            reset,
    conv_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_FILTER,
        S_LOAD_WINDOW,
        S_LOAD_BUF,
        S_CLEAR,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

`ifdef CONV_SEQ_STRIDE2_EN
    localparam logic [2:0] STEP = 3'd2;
`else
    localparam logic [2:0] STEP = 3'd1;
`endif
    localparam logic [2:0] POS_MAX = 3'd4;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [7:0] r_z;
    logic [1:0] r_cnt_filter;
    logic [3:0] r_cnt_buffer;
    logic [3:0] r_cnt_sum;
    logic [2:0] r_k;
    logic [2:0] r_q;
    logic [4:0] r_n;
    logic       w_last_pos;

    assign w_last_pos = (r_k == POS_MAX) && (r_q == POS_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:        if (bus.start) w_state_next = S_LOAD_FILTER;
            S_LOAD_FILTER: if (r_cnt_filter == 2'd3) w_state_next = S_LOAD_WINDOW;
            S_LOAD_WINDOW: if (r_cnt_buffer == 4'd15) w_state_next = S_LOAD_BUF;
            S_LOAD_BUF:    w_state_next = S_CLEAR;
            S_CLEAR:       w_state_next = S_MAC;
            S_MAC:         if (r_cnt_sum == 4'd15) w_state_next = S_WRITE;
            S_WRITE:       w_state_next = w_last_pos ? S_DONE : S_LOAD_BUF;
            S_DONE:        w_state_next = S_IDLE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    // Counters wrap to 0 at the end of their phase, so they read 0 whenever idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_cnt_filter <= '0;
            r_cnt_buffer <= '0;
            r_cnt_sum    <= '0;
            r_k          <= '0;
            r_q          <= '0;
            r_n          <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_x <= bus.x;
                r_y <= bus.y;
                r_z <= bus.z;
            end
            if (r_state == S_LOAD_FILTER) r_cnt_filter <= r_cnt_filter + 2'd1;
            if (r_state == S_LOAD_WINDOW) r_cnt_buffer <= r_cnt_buffer + 4'd1;
            if (r_state == S_MAC)         r_cnt_sum    <= r_cnt_sum + 4'd1;
            if (r_state == S_WRITE) begin
                if (w_last_pos) begin
                    r_k <= '0;
                    r_q <= '0;
                    r_n <= '0;
                end else begin
                    r_n <= r_n + 5'd1;
                    if (r_q == POS_MAX) begin
                        r_q <= '0;
                        r_k <= r_k + STEP;
                    end else begin
                        r_q <= r_q + STEP;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.busy           = (r_state != S_IDLE);
        bus.done           = (r_state == S_DONE);
        bus.load_filter    = (r_state == S_LOAD_FILTER);
        bus.load_window    = (r_state == S_LOAD_WINDOW);
        bus.load_buffer    = (r_state == S_LOAD_BUF);
        bus.sum_reset      = (r_state == S_CLEAR);
        bus.sum_en         = (r_state == S_MAC);
        bus.write          = (r_state == S_WRITE);
        bus.address        = '0;
        bus.memory_offset  = '0;
        bus.counter_filter = r_cnt_filter;
        bus.counter_buffer = r_cnt_buffer;
        bus.counter_sum    = r_cnt_sum;
        bus.k              = r_k;
        bus.q              = r_q;
        unique case (r_state)
            S_LOAD_FILTER: bus.address = r_x + {6'd0, r_cnt_filter};
            S_LOAD_WINDOW: bus.address = r_y + {4'd0, r_cnt_buffer};
            S_WRITE: begin
                bus.address       = r_z + {5'd0, r_n[4:2]};
                bus.memory_offset = r_n[1:0];
            end
            default: bus.address = '0;
        endcase
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: per-cycle reference model, write scoreboard, reset/start corners.
// Honours CONV_SEQ_STRIDE2_EN the same way as the design.
module tb_conv_sequencer;

`ifdef CONV_SEQ_STRIDE2_EN
    localparam int SIDE     = 3;
    localparam int STEP     = 2;
    localparam int DONE_CYC = 192;
    localparam int LAST_OFF = 2;
    localparam int GLITCH2  = 150;
`else
    localparam int SIDE     = 5;
    localparam int STEP     = 1;
    localparam int DONE_CYC = 496;
    localparam int LAST_OFF = 6;
    localparam int GLITCH2  = 300;
`endif
    localparam int NPOS = SIDE * SIDE;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       lf;
        logic       lw;
        logic       lb;
        logic       sr;
        logic       se;
        logic       wr;
        logic [7:0] addr;
        logic [1:0] off;
        logic [1:0] cf;
        logic [3:0] cb;
        logic [3:0] cs;
        logic [2:0] k;
        logic [2:0] q;
    } out_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
        logic [7:0] exp_first_wr;
        logic [7:0] exp_last_wr;
        int         exp_done;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [9:0] sb[$];

    conv_sequencer_if u_if ();

    conv_sequencer u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t sample();
        out_t s;
        s.busy = u_if.busy;
        s.done = u_if.done;
        s.lf   = u_if.load_filter;
        s.lw   = u_if.load_window;
        s.lb   = u_if.load_buffer;
        s.sr   = u_if.sum_reset;
        s.se   = u_if.sum_en;
        s.wr   = u_if.write;
        s.addr = u_if.address;
        s.off  = u_if.memory_offset;
        s.cf   = u_if.counter_filter;
        s.cb   = u_if.counter_buffer;
        s.cs   = u_if.counter_sum;
        s.k    = u_if.k;
        s.q    = u_if.q;
        return s;
    endfunction

    // Expected outputs in cycle c after the accepting edge, straight from the cycle timeline.
    function automatic out_t model(input int c, input logic [7:0] x, y, z);
        out_t e;
        int   p;
        int   r;
        e = '0;
        if (c >= 1 && c <= DONE_CYC) e.busy = 1'b1;
        if (c >= 1 && c <= 4) begin
            e.lf   = 1'b1;
            e.addr = x + 8'(c - 1);
            e.cf   = 2'(c - 1);
        end else if (c >= 5 && c <= 20) begin
            e.lw   = 1'b1;
            e.addr = y + 8'(c - 5);
            e.cb   = 4'(c - 5);
        end else if (c >= 21 && c < DONE_CYC) begin
            p   = (c - 21) / 19;
            r   = (c - 21) % 19;
            e.k = 3'((p / SIDE) * STEP);
            e.q = 3'((p % SIDE) * STEP);
            if (r == 0) e.lb = 1'b1;
            else if (r == 1) e.sr = 1'b1;
            else if (r <= 17) begin
                e.se = 1'b1;
                e.cs = 4'(r - 2);
            end else begin
                e.wr   = 1'b1;
                e.addr = z + 8'(p / 4);
                e.off  = 2'(p % 4);
            end
        end else if (c == DONE_CYC) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    // Runs one full sequence; pulse drives start, glitch adds stray starts, keep holds start high.
    task automatic run(input logic [7:0] ax, ay, az, input bit pulse, glitch, keep,
                       output int first_wr, output int last_wr, output int done_seen);
        out_t       act;
        out_t       exp;
        logic [9:0] e_wr;
        if (pulse) begin
            u_if.start = 1'b1;
            u_if.x     = ax;
            u_if.y     = ay;
            u_if.z     = az;
        end
        for (int p = 0; p < NPOS; p++) sb.push_back({az + 8'(p / 4), 2'(p % 4)});
        first_wr  = -1;
        last_wr   = -1;
        done_seen = -1;
        @(posedge clk);
        for (int c = 1; c <= DONE_CYC + 1; c++) begin
            @(negedge clk);
            act = sample();
            exp = model(c, ax, ay, az);
            check($sformatf("cycle %0d outputs", c), 64'(act), 64'(exp));
            if (act.wr) begin
                if (sb.size() == 0) begin
                    check($sformatf("unexpected write cycle %0d", c), 64'(1), 64'(0));
                end else begin
                    e_wr = sb.pop_front();
                    check($sformatf("write addr/lane cycle %0d", c), 64'({act.addr, act.off}), 64'(e_wr));
                end
                if (first_wr < 0) first_wr = int'(act.addr);
                last_wr = int'(act.addr);
            end
            if (act.done && done_seen < 0) done_seen = c;
            if (c == 1 && !keep) begin
                u_if.start = 1'b0;
                u_if.x     = ~ax;
                u_if.y     = ~ay;
                u_if.z     = ~az;
            end
            if (glitch && (c == 49 || c == GLITCH2 - 1)) u_if.start = 1'b1;
            if (glitch && (c == 50 || c == GLITCH2)) u_if.start = 1'b0;
        end
        check("scoreboard drained", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        vec_t vecs[4];
        out_t act;
        int   fw;
        int   lw;
        int   dn;
        int   n_wr;
        int   n_dn;
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        u_if.start = 1'b0;
        u_if.x     = '0;
        u_if.y     = '0;
        u_if.z     = '0;

        vecs[0] = '{8'h10, 8'h20, 8'h40, 8'h40, 8'h40 + 8'(LAST_OFF), DONE_CYC};
        vecs[1] = '{8'hFE, 8'hF8, 8'hFF, 8'hFF, 8'hFF + 8'(LAST_OFF), DONE_CYC};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'(LAST_OFF), DONE_CYC};
        vecs[3] = '{8'hA5, 8'h3C, 8'h7E, 8'h7E, 8'h7E + 8'(LAST_OFF), DONE_CYC};

        repeat (3) @(negedge clk);
        check("reset outputs", 64'(sample()), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", 64'(sample()), 64'(0));

        // Vector 1 also carries stray start pulses that must be ignored.
        for (int i = 0; i < 4; i++) begin
            run(vecs[i].x, vecs[i].y, vecs[i].z, 1'b1, (i == 1), 1'b0, fw, lw, dn);
            check($sformatf("vec%0d first write addr", i), 64'(fw), 64'(vecs[i].exp_first_wr));
            check($sformatf("vec%0d last write addr", i), 64'(lw), 64'(vecs[i].exp_last_wr));
            check($sformatf("vec%0d done cycle", i), 64'(dn), 64'(vecs[i].exp_done));
        end

        // start held high: second run's first LOAD_FILTER cycle is DONE+2.
        run(8'h31, 8'h52, 8'h73, 1'b1, 1'b0, 1'b1, fw, lw, dn);
        check("held start run1 done", 64'(dn), 64'(DONE_CYC));
        run(8'h31, 8'h52, 8'h73, 1'b0, 1'b0, 1'b0, fw, lw, dn);
        check("held start run2 done", 64'(dn), 64'(DONE_CYC));

        // Reset asserted mid-MAC at cycle 100.
        u_if.start = 1'b1;
        u_if.x     = 8'h10;
        u_if.y     = 8'h20;
        u_if.z     = 8'h40;
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) u_if.start = 1'b0;
        end
        check("in MAC before reset", 64'(u_if.sum_en), 64'(1));
        rst = 1'b1;
        #1;
        act = sample();
        check("outputs zero on async reset", 64'(act), 64'(0));
        @(negedge clk);
        rst  = 1'b0;
        n_wr = 0;
        n_dn = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (u_if.write) n_wr++;
            if (u_if.done) n_dn++;
        end
        check("no write after abort", 64'(n_wr), 64'(0));
        check("no done after abort", 64'(n_dn), 64'(0));
        check("idle after abort", 64'(sample()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
